// File: rtl/gg_vec_pkg.sv
// Shared definitions for the Givens-generation vectoring cell: FSM encoding,
// iteration-counter sizing and the shift terms of the ~1/K gain-compensation constant.
package gg_vec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRE_A  = 3'd1,
    ST_ITER_A = 3'd2,
    ST_PRE_B  = 3'd3,
    ST_ITER_B = 3'd4,
    ST_COMP   = 3'd5
  } gg_state_e;

  // 2^-1 + 2^-3 - 2^-6 - 2^-9 ~= 0.6074 ~= 1/K
  localparam int GG_COMP_SH0 = 1;
  localparam int GG_COMP_SH1 = 3;
  localparam int GG_COMP_SH2 = 6;
  localparam int GG_COMP_SH3 = 9;

  function automatic int gg_cnt_w(input int iter_num);
    return (iter_num < 2) ? 1 : $clog2(iter_num);
  endfunction

endpackage

// File: rtl/gg_vec_iter.sv
// One combinational CORDIC vectoring micro-rotation: (x, y, shift) -> (x', y', d).
// d=1 rotates y toward zero from above; shared by both vectoring passes.
module gg_vec_iter #(
  parameter int XW = 18,
  parameter int SW = 4
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic        [SW-1:0] sh_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic                 d_o
);

  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;

  always_comb begin
    d_o = ~y_i[XW-1];
    xs  = x_i >>> sh_i;
    ys  = y_i >>> sh_i;
    if (d_o) begin
      x_o = x_i + ys;
      y_o = y_i - xs;
    end else begin
      x_o = x_i - ys;
      y_o = y_i + xs;
    end
  end

endmodule

// File: rtl/gg_vec.sv
// Givens-generation boundary cell: CORDIC vectoring, one micro-rotation per cycle, emitting
// im->re and re->re direction streams and the column pivot r. Optional macro: GG_GAIN_COMP_EN.
module gg_vec
  import gg_vec_pkg::*;
#(
  parameter int INOUT_WIDRH = 16,
  parameter int ITER_NUM    = 9
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_data_valid,
  input  logic [2*INOUT_WIDRH-1:0]   i_data,
  input  logic                       i_first_in,
  input  logic                       i_last_in,
  output logic                       o_ready,
  output logic                       o_d_im2re_valid,
  output logic                       o_d_im2re,
  output logic                       o_d_re2re_valid,
  output logic                       o_d_re2re,
  output logic                       o_r_valid,
  output logic [INOUT_WIDRH-1:0]     o_r
);

  localparam int W  = INOUT_WIDRH;
  localparam int XW = W + 2;
  localparam int CW = gg_cnt_w(ITER_NUM);
  localparam logic [CW-1:0] LAST_IT = CW'(ITER_NUM - 1);

  gg_state_e            state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d, r_q, r_d;
  logic        [CW-1:0] cnt_q, cnt_d;
  logic                 first_q, first_d, last_q, last_d;
  logic                 col_q, col_d, phb_q, phb_d;
  logic                 rv_q, rv_d;
  logic [W-1:0]         or_q, or_d;

  logic signed [XW-1:0] it_x, it_y, comp_x, res;
  logic                 it_d, pass_done;

  gg_vec_iter #(.XW(XW), .SW(CW)) u_iter (
    .x_i  (x_q),
    .y_i  (y_q),
    .sh_i (cnt_q),
    .x_o  (it_x),
    .y_o  (it_y),
    .d_o  (it_d)
  );

`ifdef GG_GAIN_COMP_EN
  localparam bit COMP_EN = 1'b1;
  assign comp_x = (x_q >>> GG_COMP_SH0) + (x_q >>> GG_COMP_SH1)
                - (x_q >>> GG_COMP_SH2) - (x_q >>> GG_COMP_SH3);
`else
  localparam bit COMP_EN = 1'b0;
  assign comp_x = x_q;
`endif

  // A vectoring result is never negative in practice; clamp defensively anyway.
  function automatic logic [W-1:0] sat_r(input logic signed [XW-1:0] v);
    if (v[XW-1])              return '0;
    else if (|v[XW-2:W-1])    return {1'b0, {(W-1){1'b1}}};
    else                      return v[W-1:0];
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      col_q   <= 1'b0;
      phb_q   <= 1'b0;
      rv_q    <= 1'b0;
      or_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
      col_q   <= col_d;
      phb_q   <= phb_d;
      rv_q    <= rv_d;
      or_q    <= or_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    last_d    = last_q;
    col_d     = col_q;
    phb_d     = phb_q;
    rv_d      = 1'b0;
    or_d      = or_q;
    pass_done = 1'b0;
    res       = it_x;
    case (state_q)
      ST_IDLE: if (i_data_valid) begin
        x_d     = XW'($signed(i_data[W-1:0]));
        y_d     = XW'($signed(i_data[2*W-1:W]));
        first_d = i_first_in | ~col_q;
        last_d  = i_last_in;
        phb_d   = 1'b0;
        state_d = ST_PRE_A;
      end
      ST_PRE_A, ST_PRE_B: begin
        if (x_q[XW-1]) begin
          x_d = -x_q;
          y_d = -y_q;
        end
        cnt_d   = '0;
        state_d = (state_q == ST_PRE_A) ? ST_ITER_A : ST_ITER_B;
      end
      ST_ITER_A, ST_ITER_B: begin
        x_d   = it_x;
        y_d   = it_y;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IT) begin
          if (COMP_EN) state_d = ST_COMP;
          else         pass_done = 1'b1;
        end
      end
      ST_COMP: begin
        pass_done = 1'b1;
        res       = comp_x;
      end
      default: state_d = ST_IDLE;
    endcase

    // End of a pass either closes the element or chains the pivot into phase B.
    if (pass_done) begin
      if (phb_q || first_q) begin
        r_d     = res;
        col_d   = ~last_q;
        state_d = ST_IDLE;
        if (last_q) begin
          rv_d = 1'b1;
          or_d = sat_r(res);
        end
      end else begin
        x_d     = r_q;
        y_d     = res;
        phb_d   = 1'b1;
        state_d = ST_PRE_B;
      end
    end
  end

  always_comb begin
    o_ready         = (state_q == ST_IDLE);
    o_d_im2re_valid = 1'b0;
    o_d_im2re       = 1'b0;
    o_d_re2re_valid = 1'b0;
    o_d_re2re       = 1'b0;
    case (state_q)
      ST_PRE_A:  begin o_d_im2re_valid = 1'b1; o_d_im2re = x_q[XW-1]; end
      ST_ITER_A: begin o_d_im2re_valid = 1'b1; o_d_im2re = it_d;      end
      ST_PRE_B:  begin o_d_re2re_valid = 1'b1;                        end
      ST_ITER_B: begin o_d_re2re_valid = 1'b1; o_d_re2re = it_d;      end
      default: ;
    endcase
  end

  assign o_r_valid = rv_q;
  assign o_r       = or_q;

endmodule

// File: tb/tb_gg_vec.sv
// Directed self-checking bench for gg_vec (W=16, ITER_NUM=9), both gain-compensation builds.
`timescale 1ns/1ps
module tb_gg_vec;

  localparam int W = 16;
`ifdef GG_GAIN_COMP_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dv = 1'b0;
  logic [2*W-1:0] data = '0;
  logic          first = 1'b0;
  logic          last = 1'b0;
  logic          o_ready, im_v, im_d, re_v, re_d, r_v;
  logic [W-1:0]  o_r;

  gg_vec #(.INOUT_WIDRH(W), .ITER_NUM(9)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_data_valid    (dv),
    .i_data          (data),
    .i_first_in      (first),
    .i_last_in       (last),
    .o_ready         (o_ready),
    .o_d_im2re_valid (im_v),
    .o_d_im2re       (im_d),
    .o_d_re2re_valid (re_v),
    .o_d_re2re       (re_d),
    .o_r_valid       (r_v),
    .o_r             (o_r)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int im_cnt = 0;
  int re_cnt = 0;
  int rv_cnt = 0;
  logic im_bits [0:1023];

  always @(negedge clk) begin
    if (im_v) begin
      im_bits[im_cnt] <= im_d;
      im_cnt <= im_cnt + 1;
    end
    if (re_v) re_cnt <= re_cnt + 1;
    if (r_v)  rv_cnt <= rv_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic send(input int re, input int im, input logic f, input logic l);
    int g;
    g = 0;
    @(negedge clk);
    while (!o_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!o_ready) check("send_ready", 0, 1);
    data  = {16'(im), 16'(re)};
    first = f;
    last  = l;
    dv    = 1'b1;
    @(negedge clk);
    dv    = 1'b0;
  endtask

  // Counts negedges with o_ready low; returns at the first idle negedge.
  task automatic wait_idle(output int busy, output int rv_now, output int r_now);
    busy = 0;
    while (!o_ready && busy < 200) begin
      busy++;
      @(negedge clk);
    end
    rv_now = int'(r_v);
    r_now  = int'(o_r);
  endtask

  function automatic logic [9:0] stream_at(input int base);
    logic [9:0] v;
    for (int k = 0; k < 10; k++) v[9-k] = im_bits[base+k];
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int busy, rvn, rn, bi, br, bv;
    #12;
    check("rst_ready", int'(o_ready), 1);
    check("rst_r", int'(o_r), 0);
    check("rst_rvalid", int'(r_v), 0);
    check("rst_streams", int'(im_v | re_v), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single-element column, negative real axis
    bi = im_cnt; br = re_cnt;
    send(-1000, 0, 1'b1, 1'b1);
    wait_idle(busy, rvn, rn);
    check("t2_busy", busy, 10 + EXTRA);
    check("t2_rvalid", rvn, 1);
`ifdef GG_GAIN_COMP_EN
    check_rng("t2_r", rn, 998, 1002);
`else
    check_rng("t2_r", rn, 1645, 1649);
`endif
    #1;
    check("t2_im_len", im_cnt - bi, 10);
    check("t2_re_len", re_cnt - br, 0);
    check("t2_bits", int'(stream_at(bi)), int'(10'b1100010110));

    // reset in the middle of phase A
    send(100, 50, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t1_im_v", int'(im_v), 0);
    check("t1_re_v", int'(re_v), 0);
    check("t1_ready", int'(o_ready), 1);
    check("t1_r", int'(o_r), 0);
    bi = im_cnt; bv = rv_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("t1_no_rvalid", rv_cnt - bv, 0);
    check("t1_no_stream", im_cnt - bi, 0);

    // two-element column
    send(300, 400, 1'b1, 1'b0);
    wait_idle(busy, rvn, rn);
    check("t3_busy1", busy, 10 + EXTRA);
    check("t3_rvalid1", rvn, 0);
    #1;
    bi = im_cnt; br = re_cnt;
    send(0, 1200, 1'b0, 1'b1);
    wait_idle(busy, rvn, rn);
    check("t3_busy2", busy, 20 + 2*EXTRA);
    check("t3_rvalid2", rvn, 1);
`ifdef GG_GAIN_COMP_EN
    check_rng("t3_r", rn, 1296, 1304);
`else
    check_rng("t3_r", rn, 3520, 3532);
`endif
    #1;
    check("t3_re_len", re_cnt - br, 10);
    check("t3_im_len", im_cnt - bi, 10);

    // non-first element with valid pulses while busy
    send(300, 400, 1'b1, 1'b0);
    wait_idle(busy, rvn, rn);
    #1;
    bi = im_cnt; br = re_cnt; bv = rv_cnt;
    send(0, 500, 1'b0, 1'b1);
    busy = 0;
    while (!o_ready && busy < 200) begin
      busy++;
      dv   = (busy < 15) && busy[0];
      data = $urandom;
      @(negedge clk);
    end
    dv = 1'b0;
    check("t4_busy", busy, 20 + 2*EXTRA);
`ifdef GG_GAIN_COMP_EN
    check_rng("t4_r", int'(o_r), 703, 711);
`else
    check_rng("t4_r", int'(o_r), 1910, 1926);
`endif
    repeat (15) @(negedge clk);
    #1;
    check("t4_im_len", im_cnt - bi, 10);
    check("t4_re_len", re_cnt - br, 10);
    check("t4_rv_cnt", rv_cnt - bv, 1);
    check("t4_ready", int'(o_ready), 1);

    // zero input
    bi = im_cnt;
    send(0, 0, 1'b1, 1'b1);
    wait_idle(busy, rvn, rn);
    check("t5_rvalid", rvn, 1);
    check("t5_r", rn, 0);
    #1;
    check("t5_bits", int'(stream_at(bi)), int'(10'b0111111111));

    // restart a column while one is open
    send(300, 400, 1'b1, 1'b0);
    wait_idle(busy, rvn, rn);
    #1;
    br = re_cnt; bv = rv_cnt;
    send(0, 1200, 1'b1, 1'b1);
    wait_idle(busy, rvn, rn);
    check("t6_busy", busy, 10 + EXTRA);
    check("t6_rvalid", rvn, 1);
`ifdef GG_GAIN_COMP_EN
    check_rng("t6_r", rn, 1196, 1204);
`else
    check_rng("t6_r", rn, 1972, 1980);
`endif
    repeat (3) @(negedge clk);
    #1;
    check("t6_re_len", re_cnt - br, 0);
    check("t6_rv_cnt", rv_cnt - bv, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
